// File: rtl/prog_pkg.sv
// Shared constants and types for the program fetch stage.
package prog_pkg;

    localparam int AW = 9;
    localparam int DW = 12;

    typedef logic [AW-1:0] pc_t;
    typedef logic [DW-1:0] instr_t;

    localparam pc_t RESET_VEC = 9'h000;

    // Program counters wrap modulo 2^AW.
    function automatic pc_t pc_inc(input pc_t pc);
        return pc + pc_t'(1);
    endfunction

endpackage

// File: rtl/prog_ret_stack.sv
// Circular LIFO of return addresses; overflow overwrites the oldest entry.
// Instantiated by prog_fetch only when PROG_FETCH_RSTACK_EN is defined.
module prog_ret_stack
    import prog_pkg::*;
#(
    parameter int STACK_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [AW-1:0] push_data,
    input  logic          pop,
    input  logic          conflict,
    output logic [AW-1:0] top,
    output logic          err
);

    localparam int PW = $clog2(STACK_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(STACK_DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          err_q, err_d;
    logic [PW-1:0] top_idx;
    logic          empty, full;
    pc_t           mem_q [STACK_DEPTH];

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign top_idx = wr_ptr_q - PW'(1);
    assign top     = empty ? RESET_VEC : mem_q[top_idx];
    assign err     = err_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        err_d    = err_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (full) err_d = 1'b1;
            else      count_d = count_q + 1'b1;
        end else if (pop) begin
            if (empty) begin
                err_d = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q - PW'(1);
                count_d  = count_q - 1'b1;
            end
        end
        if (conflict) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // NOTE: storage is not reset; count_q gates every read, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/prog_fetch.sv
// Instruction fetch stage: owns the PC, absorbs the 1-cycle ROM latency, handles redirects.
// Optional return-address stack enabled by defining PROG_FETCH_RSTACK_EN.
module prog_fetch
    import prog_pkg::*;
#(
    parameter int STACK_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [AW-1:0] rom_adrs,
    input  logic [DW-1:0] rom_data,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    input  logic          redir_valid,
    input  logic [AW-1:0] redir_target,
    input  logic          redir_call,
    input  logic [AW-1:0] redir_ret,
    input  logic          ret_valid,
    output logic          stk_err
);

    pc_t  fetch_pc_q, fetch_pc_d;
    pc_t  pc_f2_q, pc_f2_d;
    logic v_f2_q, v_f2_d;
    logic stall, advance;
    logic ret_req;
    pc_t  ret_target;

`ifdef PROG_FETCH_RSTACK_EN
    assign ret_req = ret_valid;

    prog_ret_stack #(
        .STACK_DEPTH(STACK_DEPTH)
    ) u_ret_stack (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (redir_valid && redir_call),
        .push_data(redir_ret),
        .pop      (ret_valid && !redir_valid),
        .conflict (redir_valid && ret_valid),
        .top      (ret_target),
        .err      (stk_err)
    );
`else
    logic unused_stack_inputs;
    assign unused_stack_inputs = ^{ret_valid, redir_call, redir_ret};
    assign ret_req    = 1'b0;
    assign ret_target = RESET_VEC;
    assign stk_err    = 1'b0;
`endif

    assign stall   = v_f2_q && !instr_ready;
    assign advance = !stall || redir_valid || ret_req;

    // The ROM registers this address, so redirect and ready feed it combinationally.
    always_comb begin
        rom_adrs = fetch_pc_q;
        if (!rst_n)           rom_adrs = RESET_VEC;
        else if (redir_valid) rom_adrs = redir_target;
        else if (ret_req)     rom_adrs = ret_target;
        else if (stall)       rom_adrs = pc_f2_q;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pc_f2_d    = pc_f2_q;
        v_f2_d     = v_f2_q;
        if (advance) begin
            pc_f2_d    = rom_adrs;
            v_f2_d     = 1'b1;
            fetch_pc_d = pc_inc(rom_adrs);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_VEC;
            pc_f2_q    <= RESET_VEC;
            v_f2_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pc_f2_q    <= pc_f2_d;
            v_f2_q     <= v_f2_d;
        end
    end

    assign instr       = rom_data;
    assign instr_pc    = pc_f2_q;
    assign instr_valid = v_f2_q && !redir_valid && !ret_req;

endmodule

// File: tb/tb_prog_fetch.sv
// Self-checking bench for prog_fetch: directed vector tables plus a randomized run
// against a transaction-level model of the instruction stream and return stack.
module tb_prog_fetch;
    import prog_pkg::*;

    localparam int DEPTH = 4;
`ifdef PROG_FETCH_RSTACK_EN
    localparam bit RET_EN = 1'b1;
`else
    localparam bit RET_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] rom_adrs;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic          redir_valid;
    logic [AW-1:0] redir_target;
    logic          redir_call;
    logic [AW-1:0] redir_ret;
    logic          ret_valid;
    logic          stk_err;

    prog_fetch #(
        .STACK_DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom_adrs    (rom_adrs),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redir_valid (redir_valid),
        .redir_target(redir_target),
        .redir_call  (redir_call),
        .redir_ret   (redir_ret),
        .ret_valid   (ret_valid),
        .stk_err     (stk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic instr_t rom_fn(input pc_t a);
        return instr_t'(a) ^ 12'hA5A;
    endfunction

    // Registered-read ROM model.
    always @(posedge clk) rom_data <= rom_fn(rom_adrs);

    typedef struct {
        logic rdy;
        logic rv;
        pc_t  tgt;
        logic call;
        pc_t  ra;
        logic rt;
        logic ev;
        pc_t  epc;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rdy, input logic rv, input pc_t tgt, input logic call,
                                input pc_t ra, input logic rt, input logic ev, input pc_t epc);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.tgt = tgt; v.call = call;
        v.ra = ra; v.rt = rt; v.ev = ev; v.epc = epc;
        return v;
    endfunction

    function automatic vec_t nrm(input logic ev, input pc_t epc);
        return mk(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, ev, epc);
    endfunction

    task automatic set_inputs(input logic rdy, input logic rv, input pc_t tgt, input logic call,
                              input pc_t ra, input logic rt);
        instr_ready  = rdy;
        redir_valid  = rv;
        redir_target = tgt;
        redir_call   = call;
        redir_ret    = ra;
        ret_valid    = rt;
    endtask

    task automatic apply(input vec_t v, input string tag);
        set_inputs(v.rdy, v.rv, v.tgt, v.call, v.ra, v.rt);
        @(negedge clk);
        check({tag, " valid"}, 32'(instr_valid), 32'(v.ev));
        check({tag, " pc"}, 32'(instr_pc), 32'(v.epc));
        if (v.ev) check({tag, " instr"}, 32'(instr), 32'(rom_fn(v.epc)));
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input vec_t tbl[$], input string name);
        foreach (tbl[i]) apply(tbl[i], $sformatf("%s[%0d]", name, i));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        set_inputs(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        #1;
        check("reset rom_adrs", 32'(rom_adrs), 32'(RESET_VEC));
        check("reset instr_valid", 32'(instr_valid), 32'd0);
        check("reset instr_pc", 32'(instr_pc), 32'(RESET_VEC));
        check("reset stk_err", 32'(stk_err), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t main_tbl[$];
        vec_t seq[$];
        pc_t  exp_pc;
        pc_t  mstk[$];
        bit   started;
        bit   exp_err;
        bit   rt_eff;
        bit   ev;

        rst_n = 1'b0;
        set_inputs(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);

        // Start-up stream, 5-cycle stall at 0x010, redirect to 0x04B, wrap at 0x1FF.
        main_tbl.push_back(nrm(1'b0, RESET_VEC));
        for (int p = 0; p < 16; p++) main_tbl.push_back(nrm(1'b1, pc_t'(p)));
        for (int k = 0; k < 5; k++) main_tbl.push_back(mk(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 9'h010));
        for (int p = 16; p < 32; p++) main_tbl.push_back(nrm(1'b1, pc_t'(p)));
        main_tbl.push_back(mk(1'b1, 1'b1, 9'h04B, 1'b0, '0, 1'b0, 1'b0, 9'h020));
        main_tbl.push_back(nrm(1'b1, 9'h04B));
        main_tbl.push_back(nrm(1'b1, 9'h04C));
        main_tbl.push_back(mk(1'b1, 1'b1, 9'h1FD, 1'b0, '0, 1'b0, 1'b0, 9'h04D));
        main_tbl.push_back(nrm(1'b1, 9'h1FD));
        main_tbl.push_back(nrm(1'b1, 9'h1FE));
        main_tbl.push_back(nrm(1'b1, 9'h1FF));
        main_tbl.push_back(nrm(1'b1, 9'h000));

        do_reset();
        run_table(main_tbl, "main");

`ifdef PROG_FETCH_RSTACK_EN
        // Call then return, then 5 nested calls and 5 returns (overflow + underflow).
        seq.delete();
        seq.push_back(mk(1'b1, 1'b1, 9'h100, 1'b1, 9'h031, 1'b0, 1'b0, 9'h001));
        seq.push_back(nrm(1'b1, 9'h100));
        seq.push_back(mk(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 9'h101));
        seq.push_back(nrm(1'b1, 9'h031));
        run_table(seq, "callret");
        check("callret stk_err", 32'(stk_err), 32'd0);

        for (int i = 0; i < 5; i++) begin
            apply(mk(1'b1, 1'b1, pc_t'(9'h140 + i), 1'b1, pc_t'(9'h0A0 + i), 1'b0, 1'b0,
                     (i == 0) ? 9'h032 : pc_t'(9'h140 + i - 1)), $sformatf("push[%0d]", i));
            if (i == 3) check("stk_err after 4 pushes", 32'(stk_err), 32'd0);
        end
        check("stk_err after 5th push", 32'(stk_err), 32'd1);
        seq.delete();
        seq.push_back(mk(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 9'h144));
        seq.push_back(mk(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 9'h0A4));
        seq.push_back(mk(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 9'h0A3));
        seq.push_back(mk(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 9'h0A2));
        seq.push_back(mk(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 9'h0A1));
        seq.push_back(nrm(1'b1, 9'h000));
        run_table(seq, "pop");

        // Redirect and return together: redirect wins, stack untouched, error flagged.
        do_reset();
        seq.delete();
        seq.push_back(nrm(1'b0, 9'h000));
        seq.push_back(nrm(1'b1, 9'h000));
        seq.push_back(mk(1'b1, 1'b1, 9'h180, 1'b1, 9'h055, 1'b0, 1'b0, 9'h001));
        seq.push_back(nrm(1'b1, 9'h180));
        seq.push_back(mk(1'b1, 1'b1, 9'h077, 1'b0, '0, 1'b1, 1'b0, 9'h181));
        run_table(seq, "conflict");
        check("conflict stk_err", 32'(stk_err), 32'd1);
        seq.delete();
        seq.push_back(nrm(1'b1, 9'h077));
        seq.push_back(mk(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 9'h078));
        seq.push_back(nrm(1'b1, 9'h055));
        run_table(seq, "after_conflict");
`else
        // Without the stack, return requests and call flags have no effect.
        seq.delete();
        seq.push_back(mk(1'b1, 1'b0, '0, 1'b1, 9'h033, 1'b1, 1'b1, 9'h001));
        seq.push_back(mk(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 9'h002));
        seq.push_back(mk(1'b1, 1'b1, 9'h0F0, 1'b1, 9'h033, 1'b0, 1'b0, 9'h003));
        seq.push_back(nrm(1'b1, 9'h0F0));
        seq.push_back(mk(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 9'h0F1));
        seq.push_back(nrm(1'b1, 9'h0F2));
        run_table(seq, "noret");
        check("noret stk_err", 32'(stk_err), 32'd0);
`endif

        // Asynchronous reset while stalled with a call redirect pending.
        set_inputs(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        set_inputs(1'b0, 1'b1, 9'h1AA, 1'b1, 9'h1AB, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset rom_adrs", 32'(rom_adrs), 32'(RESET_VEC));
        check("midreset instr_valid", 32'(instr_valid), 32'd0);
        check("midreset instr_pc", 32'(instr_pc), 32'(RESET_VEC));
        check("midreset stk_err", 32'(stk_err), 32'd0);
        set_inputs(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized run against a model of the accepted-instruction stream.
        exp_pc  = RESET_VEC;
        started = 1'b0;
        exp_err = 1'b0;
        mstk.delete();
        for (int n = 0; n < 3000; n++) begin
            set_inputs($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, pc_t'($urandom),
                       1'($urandom_range(0, 1)), pc_t'($urandom), $urandom_range(0, 9) == 0);
            @(negedge clk);
            rt_eff = RET_EN && ret_valid;
            ev     = started && !redir_valid && !rt_eff;
            check("rnd valid", 32'(instr_valid), 32'(ev));
            if (started) begin
                check("rnd pc", 32'(instr_pc), 32'(exp_pc));
                check("rnd instr", 32'(instr), 32'(rom_fn(exp_pc)));
            end
            check("rnd stk_err", 32'(stk_err), 32'(exp_err));

            if (redir_valid) begin
                if (RET_EN && redir_call) begin
                    if (mstk.size() == DEPTH) begin
                        mstk.delete(0);
                        exp_err = 1'b1;
                    end
                    mstk.push_back(redir_ret);
                end
                if (rt_eff) exp_err = 1'b1;
                exp_pc = redir_target;
            end else if (rt_eff) begin
                if (mstk.size() == 0) begin
                    exp_pc  = RESET_VEC;
                    exp_err = 1'b1;
                end else begin
                    exp_pc = mstk.pop_back();
                end
            end else if (ev && instr_ready) begin
                exp_pc = exp_pc + pc_t'(1);
            end
            started = 1'b1;
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_fetch.md
Name: prog_fetch

Overview:
- Instruction fetch stage sitting directly upstream of the 512x12 program ROM and downstream of nothing but execute redirects.
- Owns the program counter, drives the ROM address, and absorbs the ROM's 1-cycle registered read latency.
- Presents each fetched 12-bit instruction and its PC to decode through a valid/ready handshake.
- Handles jump/call redirects from execute and, optionally, returns via an internal return-address stack.

Parameters:
- AW, 9: program address width; PC arithmetic wraps modulo 2^AW.
- DW, 12: instruction width.
- RESET_VEC, 9'h000: PC value after reset.
- STACK_DEPTH, 4: return-stack entries, power of two; only used with PROG_FETCH_RSTACK_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- rom_adrs  out  AW  ROM address; ROM returns data one clk later.
- rom_data  in  DW  ROM registered read data.
- instr  out  DW  instruction to decode; equals rom_data.
- instr_pc  out  AW  address of instr.
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  decode accepts when instr_valid && instr_ready.
- redir_valid  in  1  execute redirect request, one-cycle pulse.
- redir_target  in  AW  redirect destination.
- redir_call  in  1  with redir_valid: push redir_ret.
- redir_ret  in  AW  return address to push (caller PC+1).
- ret_valid  in  1  return request: pop stack top as target.
- stk_err  out  1  sticky overflow/underflow/conflict flag.

Behaviour:
- Registers: fetch_pc (next address to issue), pc_f2 (address whose data is on rom_data), v_f2.
- Reset values: fetch_pc = RESET_VEC, pc_f2 = RESET_VEC, v_f2 = 0, stack pointer = 0, stk_err = 0.
- Outputs during reset: rom_adrs = RESET_VEC, instr_valid = 0, instr_pc = RESET_VEC.
- stall = v_f2 && !instr_ready.
- rom_adrs mux, priority order, combinational:
  - redir_valid: redir_target.
  - ret_valid (stack enabled): stack top, or RESET_VEC on underflow.
  - stall: pc_f2, so the ROM re-reads and the data holds steady.
  - otherwise: fetch_pc.
- On each edge when not stalled, or when redirecting/returning: pc_f2 <= rom_adrs, v_f2 <= 1, fetch_pc <= rom_adrs + 1 (AW-bit wrap, 0x1FF -> 0x000).
- On a stall edge: all fetch registers hold.
- Output gating: instr_valid = v_f2 && !redir_valid && !ret_valid. The wrong-path instruction is never accepted in the redirect cycle.
- Redirect latency: target instruction is valid the cycle after the redir_valid/ret_valid pulse, with zero extra bubbles.
- Throughput: one instruction per clk while instr_ready = 1.
- First instruction after reset release: pc = RESET_VEC, valid in the 2nd cycle after the first clk edge with rst_n = 1.
- Combinational paths instr_ready -> rom_adrs and redir -> rom_adrs are intentional; the ROM input is a register address.
- Return stack, LIFO:
  - Push on redir_valid && redir_call.
  - Pop on ret_valid && !redir_valid.
  - Overflow: push when full overwrites the oldest entry (circular pointer), stk_err <= 1.
  - Underflow: pop when empty targets RESET_VEC, pointer unchanged, stk_err <= 1.
- Simultaneous redir_valid && ret_valid: redirect wins, return dropped, stk_err <= 1.
- stk_err clears only on reset.
- Reset mid-stall or mid-redirect: all state returns to reset values immediately (async); no partial push retained.

Optional Feature:
- PROG_FETCH_RSTACK_EN defined:
  - Return stack instantiated; ret_valid, redir_call and redir_ret are functional; stk_err behaves as above.
- PROG_FETCH_RSTACK_EN undefined:
  - No stack logic; ret_valid, redir_call and redir_ret are ignored.
  - stk_err tied 0.
  - Execute performs returns as ordinary redirects.

Decomposition:
- Shared package prog_pkg:
  - AW and DW constants, plus RESET_VEC.
  - Typedefs pc_t (logic [AW-1:0]) and instr_t (logic [DW-1:0]).
- Sub-module prog_ret_stack: STACK_DEPTH x AW circular LIFO with push/pop/top/err. Generated only under PROG_FETCH_RSTACK_EN.

Test Plan:
- Reset, instr_ready = 1 throughout, ROM model with rom[n] = n^0xA5A -> instr_pc sequence 000, 001, 002, ... with instr = rom[pc], one per clk, first valid 2 cycles after release.
- Hold instr_ready = 0 for 5 cycles while instr_pc = 0x010 -> instr/instr_pc stay 0x010/rom[0x010]; after release next accepted pc = 0x011; no skip, no duplicate.
- redir_valid pulse with target 0x04B while pc 0x020 valid -> instr_valid = 0 in that cycle; next cycle instr_pc = 0x04B, then 0x04C.
- Free run from 0x1FD -> pcs 1FD, 1FE, 1FF, 000.
- RSTACK_EN: call to 0x100 with redir_ret = 0x031, then ret_valid -> instr_pc 0x031 next cycle. Five nested calls (depth 4) then five returns -> stk_err = 1 after the 5th push; 5th pop yields target 0x000.
- RSTACK_EN: redir_valid and ret_valid in the same cycle -> redirect target fetched, stack pointer unchanged, stk_err = 1.
